// File: rtl/cpu_write_buffer.sv
// Posted-write buffer between a CPU and a single-outstanding downstream bus.
// Writes are queued in a circular FIFO and drained in order. A read waits until
// the FIFO is empty, then goes to the bus. A flush waits until the FIFO is empty.
// Optional macro CPU_WRITE_BUFFER_FORWARD_EN: a read that hits a queued address
// returns the youngest matching entry's data directly.
module cpu_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic        i_flush,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = DEPTH[CW-1:0];

  typedef enum logic [1:0] {U_IDLE, U_WRITE_WAIT, U_READ_WAIT, U_FLUSH_WAIT} ustate_t;
  typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ} bstate_t;

  ustate_t        r_ustate, w_ustate_d;
  bstate_t        r_bstate, w_bstate_d;
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [29:0]    r_mem_addr [DEPTH];
  logic [31:0]    r_mem_data [DEPTH];
  logic [29:0]    r_req_addr;
  logic [31:0]    r_req_wdata;
  logic           r_ready, w_ready_d;
  logic [31:0]    r_rdata, w_rdata_d;
  logic           r_bus_request, w_bus_request_d;
  logic           r_bus_rw, w_bus_rw_d;
  logic [31:0]    r_bus_address, w_bus_address_d;
  logic [31:0]    r_bus_wdata, w_bus_wdata_d;

  logic           w_accept, w_full, w_push, w_pop;
  logic [29:0]    w_push_addr;
  logic [31:0]    w_push_data;
  logic           w_fwd_hit;
  logic [31:0]    w_fwd_data;
  logic [1:0]     w_unused_addr_lsb;

  assign w_unused_addr_lsb = i_address[1:0];
  assign w_accept = i_request && !r_ready && (r_ustate == U_IDLE);
  // Full is judged on the registered count, so a pop never frees a slot in the same cycle.
  assign w_full   = (r_count == CNT_FULL);

`ifdef CPU_WRITE_BUFFER_FORWARD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && (r_mem_addr[r_rd_ptr + AW'(k)] == i_address[31:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_mem_data[r_rd_ptr + AW'(k)];
      end
    end
  end
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = '0;
`endif

  // Next-state and control for the upstream and drain FSMs.
  always_comb begin
    w_ustate_d      = r_ustate;
    w_bstate_d      = r_bstate;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_push_addr     = i_address[31:2];
    w_push_data     = i_wdata;
    w_ready_d       = 1'b0;
    w_rdata_d       = '0;
    w_bus_request_d = r_bus_request;
    w_bus_rw_d      = r_bus_rw;
    w_bus_address_d = r_bus_address;
    w_bus_wdata_d   = r_bus_wdata;

    unique case (r_ustate)
      U_IDLE: begin
        if (w_accept) begin
          if (i_flush) begin
            if (r_count == '0) w_ready_d = 1'b1;
            else               w_ustate_d = U_FLUSH_WAIT;
          end else if (i_rw) begin
            if (w_full) begin
              w_ustate_d = U_WRITE_WAIT;
            end else begin
              w_push    = 1'b1;
              w_ready_d = 1'b1;
            end
          end else if (w_fwd_hit) begin
            w_ready_d = 1'b1;
            w_rdata_d = w_fwd_data;
          end else begin
            w_ustate_d = U_READ_WAIT;
          end
        end
      end
      U_WRITE_WAIT: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_addr = r_req_addr;
          w_push_data = r_req_wdata;
          w_ready_d   = 1'b1;
          w_ustate_d  = U_IDLE;
        end
      end
      U_READ_WAIT: begin
        if ((r_bstate == B_READ) && i_bus_ready) begin
          w_ready_d  = 1'b1;
          w_rdata_d  = i_bus_rdata;
          w_ustate_d = U_IDLE;
        end
      end
      U_FLUSH_WAIT: begin
        if (r_count == '0) begin
          w_ready_d  = 1'b1;
          w_ustate_d = U_IDLE;
        end
      end
      default: w_ustate_d = U_IDLE;
    endcase

    unique case (r_bstate)
      B_IDLE: begin
        if (r_count != '0) begin
          w_bstate_d      = B_WRITE;
          w_bus_request_d = 1'b1;
          w_bus_rw_d      = 1'b1;
          w_bus_address_d = {r_mem_addr[r_rd_ptr], 2'b00};
          w_bus_wdata_d   = r_mem_data[r_rd_ptr];
        end else if (r_ustate == U_READ_WAIT) begin
          w_bstate_d      = B_READ;
          w_bus_request_d = 1'b1;
          w_bus_rw_d      = 1'b0;
          w_bus_address_d = {r_req_addr, 2'b00};
          w_bus_wdata_d   = '0;
        end
      end
      B_WRITE, B_READ: begin
        if (i_bus_ready) begin
          w_pop           = (r_bstate == B_WRITE);
          w_bstate_d      = B_IDLE;
          w_bus_request_d = 1'b0;
          w_bus_rw_d      = 1'b0;
          w_bus_address_d = '0;
          w_bus_wdata_d   = '0;
        end
      end
      default: w_bstate_d = B_IDLE;
    endcase
  end

  // State, FIFO bookkeeping, request capture and registered outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_ustate      <= U_IDLE;
      r_bstate      <= B_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_ready       <= 1'b0;
      r_rdata       <= '0;
      r_bus_request <= 1'b0;
      r_bus_rw      <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
    end else begin
      r_ustate      <= w_ustate_d;
      r_bstate      <= w_bstate_d;
      r_ready       <= w_ready_d;
      r_rdata       <= w_rdata_d;
      r_bus_request <= w_bus_request_d;
      r_bus_rw      <= w_bus_rw_d;
      r_bus_address <= w_bus_address_d;
      r_bus_wdata   <= w_bus_wdata_d;
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_accept) begin
        r_req_addr  <= i_address[31:2];
        r_req_wdata <= i_wdata;
      end
    end
  end

  // Entry storage; validity is tracked by the count, so no reset is needed.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= w_push_addr;
      r_mem_data[r_wr_ptr] <= w_push_data;
    end
  end

  assign o_ready       = r_ready;
  assign o_rdata       = r_rdata;
  assign o_bus_request = r_bus_request;
  assign o_bus_rw      = r_bus_rw;
  assign o_bus_address = r_bus_address;
  assign o_bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_cpu_write_buffer.sv
// Directed bench for cpu_write_buffer (DEPTH=4). Honours CPU_WRITE_BUFFER_FORWARD_EN.
module tb_cpu_write_buffer;

  logic        clk = 1'b0;
  logic        i_reset, i_request, i_rw, i_flush, i_bus_ready;
  logic [31:0] i_address, i_wdata, i_bus_rdata;
  logic        o_ready, o_bus_rw, o_bus_request;
  logic [31:0] o_rdata, o_bus_address, o_bus_wdata;

  always #5 clk = ~clk;

  cpu_write_buffer #(.DEPTH(4)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_request(i_request), .i_rw(i_rw),
    .i_flush(i_flush), .i_address(i_address), .i_wdata(i_wdata), .o_ready(o_ready),
    .o_rdata(o_rdata), .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request),
    .i_bus_ready(i_bus_ready), .o_bus_address(o_bus_address), .i_bus_rdata(i_bus_rdata),
    .o_bus_wdata(o_bus_wdata)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    int          stamp;
  } bus_t;

  bus_t        log_q[$];
  int          tests = 0;
  int          fails = 0;
  int          pulses = 0;
  int          cyc = 0;
  logic        p_req = 1'b0, p_rw = 1'b0, p_rdy = 1'b0;
  logic [31:0] p_addr = '0, p_wd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; logs completed bus handshakes and checks per-cycle output rules.
  task automatic tick();
    logic drv;
    drv = i_bus_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (p_req && drv) log_q.push_back('{rw: p_rw, addr: p_addr, data: p_wd, stamp: cyc});
    if (o_bus_request) begin
      check("bus_addr_lsb", 32'(o_bus_address[1:0]), 32'd0);
      if (p_req && !drv) begin
        check("bus_stable_rw", 32'(o_bus_rw), 32'(p_rw));
        check("bus_stable_addr", o_bus_address, p_addr);
        check("bus_stable_wdata", o_bus_wdata, p_wd);
      end
    end
    if (o_ready) begin
      pulses++;
      check("ready_single", 32'(p_rdy), 32'd0);
    end else begin
      check("rdata_idle_zero", o_rdata, 32'd0);
    end
    p_req  = o_bus_request;
    p_rw   = o_bus_rw;
    p_addr = o_bus_address;
    p_wd   = o_bus_wdata;
    p_rdy  = o_ready;
  endtask

  task automatic start_req(input logic fl, input logic rw, input logic [31:0] a,
                           input logic [31:0] d);
    i_request = 1'b1;
    i_flush   = fl;
    i_rw      = rw;
    i_address = a;
    i_wdata   = d;
  endtask

  // Returns edges until o_ready (-1 on timeout) and the data seen with it.
  task automatic wait_ready(input int bound, output int n, output logic [31:0] rd);
    n  = -1;
    rd = '0;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (o_ready) begin
        n  = i;
        rd = o_rdata;
        break;
      end
    end
  endtask

  task automatic end_req();
    i_request = 1'b0;
    i_flush   = 1'b0;
    tick();
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    int          n;
    logic [31:0] rd;
    start_req(1'b0, 1'b1, a, d);
    wait_ready(10, n, rd);
    check(tag, n, 32'd1);
    end_req();
  endtask

  task automatic check_bus(input int i, input logic rw, input logic [31:0] a,
                           input logic [31:0] d);
    if (i < log_q.size()) begin
      check($sformatf("bus%0d_rw", i), 32'(log_q[i].rw), 32'(rw));
      check($sformatf("bus%0d_addr", i), log_q[i].addr, a);
      if (rw) check($sformatf("bus%0d_wdata", i), log_q[i].data, d);
    end else begin
      check($sformatf("bus%0d_present", i), log_q.size(), i + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, p0, rcyc;
    logic [31:0] rd;
    logic        done;

    i_reset = 1'b0; i_request = 1'b0; i_rw = 1'b0; i_flush = 1'b0;
    i_address = '0; i_wdata = '0; i_bus_ready = 1'b0; i_bus_rdata = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_bus_req", 32'(o_bus_request), 32'd0);
    check("rst_bus_rw", 32'(o_bus_rw), 32'd0);
    check("rst_bus_addr", o_bus_address, 32'd0);
    check("rst_bus_wdata", o_bus_wdata, 32'd0);
    i_reset = 1'b1;
    tick();

    // Single write, bus ready immediately
    log_q.delete();
    i_bus_ready = 1'b1;
    do_write("w1_latency", 32'h100, 32'hAABBCCDD);
    repeat (5) tick();
    check("w1_bus_count", log_q.size(), 32'd1);
    check_bus(0, 1'b1, 32'h100, 32'hAABBCCDD);

    // Fill with bus stalled, fifth write stalls until a pop
    log_q.delete();
    i_bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_write($sformatf("fill%0d_latency", i), 32'h10 + 4 * i, i + 1);
    start_req(1'b0, 1'b1, 32'h20, 32'd5);
    p0 = pulses;
    repeat (4) tick();
    check("full_stall_no_ready", pulses, p0);
    check("full_no_pop", log_q.size(), 32'd0);
    i_bus_ready = 1'b1;
    wait_ready(10, n, rd);
    check("full_accept_after_pop", n, 32'd2);
    end_req();
    repeat (14) tick();
    check("fill_bus_count", log_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) check_bus(i, 1'b1, 32'h10 + 4 * i, i + 1);

    // Same-address writes then a read of that address
    log_q.delete();
    i_bus_ready = 1'b0;
    do_write("raw_w1_latency", 32'h200, 32'd1);
    do_write("raw_w2_latency", 32'h200, 32'd2);
`ifdef CPU_WRITE_BUFFER_FORWARD_EN
    start_req(1'b0, 1'b0, 32'h200, 32'd0);
    wait_ready(10, n, rd);
    check("fwd_latency", n, 32'd1);
    check("fwd_rdata", rd, 32'd2);
    end_req();
    i_bus_ready = 1'b1;
    repeat (8) tick();
    check("fwd_bus_count", log_q.size(), 32'd2);
`else
    start_req(1'b0, 1'b0, 32'h200, 32'd0);
    i_bus_rdata = 32'hCAFE0001;
    i_bus_ready = 1'b1;
    wait_ready(30, n, rd);
    check("raw_read_done", 32'(n > 0), 32'd1);
    check("raw_rdata", rd, 32'hCAFE0001);
    end_req();
    repeat (3) tick();
    check("raw_bus_count", log_q.size(), 32'd3);
    check_bus(2, 1'b0, 32'h200, 32'd0);
`endif
    check_bus(0, 1'b1, 32'h200, 32'd1);
    check_bus(1, 1'b1, 32'h200, 32'd2);

    // Read miss behind three pending writes; address low bits ignored
    log_q.delete();
    i_bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_write($sformatf("rw%0d_latency", i), 32'h400 + 4 * i, 32'h40 + 4 * i);
    start_req(1'b0, 1'b0, 32'h302, 32'd0);
    i_bus_rdata = 32'h12345678;
    i_bus_ready = 1'b1;
    wait_ready(40, n, rd);
    check("miss_read_done", 32'(n > 0), 32'd1);
    check("miss_rdata", rd, 32'h12345678);
    end_req();
    repeat (3) tick();
    check("miss_bus_count", log_q.size(), 32'd4);
    for (int i = 0; i < 3; i++) check_bus(i, 1'b1, 32'h400 + 4 * i, 32'h40 + 4 * i);
    check_bus(3, 1'b0, 32'h300, 32'd0);

    // Flush with two entries, bus ready every other cycle
    log_q.delete();
    i_bus_ready = 1'b0;
    do_write("fl_w1_latency", 32'h500, 32'hA);
    do_write("fl_w2_latency", 32'h504, 32'hB);
    start_req(1'b1, 1'b0, 32'h0, 32'h0);
    done = 1'b0;
    rcyc = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      i_bus_ready = ~i_bus_ready;
      tick();
      if (o_ready) begin
        done = 1'b1;
        rcyc = cyc;
      end
    end
    check("flush_done", 32'(done), 32'd1);
    end_req();
    check("flush_bus_count", log_q.size(), 32'd2);
    check_bus(0, 1'b1, 32'h500, 32'hA);
    check_bus(1, 1'b1, 32'h504, 32'hB);
    if (log_q.size() == 2) check("flush_after_last_pop", rcyc, log_q[1].stamp + 1);
    start_req(1'b1, 1'b0, 32'h0, 32'h0);
    wait_ready(10, n, rd);
    check("flush_empty_latency", n, 32'd1);
    end_req();

    // Reset while draining three entries
    log_q.delete();
    i_bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_write($sformatf("rs%0d_latency", i), 32'h600 + 4 * i, 32'h60 + i);
    tick();
    check("rs_bus_req_before", 32'(o_bus_request), 32'd1);
    check("rs_bus_addr_before", o_bus_address, 32'h600);
    p0 = pulses;
    i_reset = 1'b0;
    tick();
    check("rs_bus_req_after", 32'(o_bus_request), 32'd0);
    check("rs_bus_addr_after", o_bus_address, 32'd0);
    check("rs_ready_after", 32'(o_ready), 32'd0);
    i_reset = 1'b1;
    i_bus_ready = 1'b1;
    repeat (6) tick();
    check("rs_no_bus_traffic", log_q.size(), 32'd0);
    check("rs_bus_idle", 32'(o_bus_request), 32'd0);
    check("rs_no_ready", pulses, p0);
    start_req(1'b1, 1'b0, 32'h0, 32'h0);
    wait_ready(10, n, rd);
    check("rs_flush_empty_latency", n, 32'd1);
    end_req();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
